cas_lock_seq: RTL



---
 rtl/cas_lock_pkg.sv | 20 ++
 rtl/cas_chain.sv | 27 ++
 rtl/cas_lock_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cas_lock_pkg.sv
// Shared types and elaboration helpers for the sequential CAS-Lock wrapper.
package cas_lock_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } lock_state_e;

  // Number of key-load beats needed to fill the key register.
  function automatic int n_beats(input int key_w, input int load_w);
    return key_w / load_w;
  endfunction

  // Legal configuration: at least two chain inputs, whole beats, one key half per chain.
  function automatic bit cfg_ok(input int n_in, input int key_w, input int load_w);
    return (n_in >= 2) && (load_w > 0) && ((key_w % load_w) == 0) && (key_w == 2 * n_in);
  endfunction

endpackage

// File: rtl/cas_chain.sv
// One cascaded AND/OR chain over the key-XORed protected inputs.
module cas_chain
  import cas_lock_pkg::*;
#(
  parameter int              N_IN     = 32,
  parameter logic [N_IN-1:0] PAT      = 32'hFFFF_0000,
  parameter logic [N_IN-1:0] INV_MASK = '0
) (
  input  logic [N_IN-1:0] in_data,
  input  logic [N_IN-1:0] key,
  output logic            acc
);

  logic [N_IN-1:0] x;
  logic            acc_v;

  // Fold the per-input terms left to right; stage i is OR when PAT[i] is set, else AND.
  always_comb begin
    x     = in_data ^ key ^ INV_MASK;
    acc_v = x[0] & x[1];
    for (int i = 2; i < N_IN; i++) begin
      acc_v = PAT[i] ? (acc_v | x[i]) : (acc_v & x[i]);
    end
    acc = acc_v;
  end

endmodule

// File: rtl/cas_lock_seq.sv
// Sequential CAS-Lock wrapper: serial key load, two cascaded chains, flipped output
// with valid/ready handshakes and a saturating oracle-query counter.
module cas_lock_seq
  import cas_lock_pkg::*;
#(
  parameter int              N_IN       = 32,
  parameter int              KEY_W      = 2 * N_IN,
  parameter int              LOAD_W     = 8,
  parameter logic [N_IN-1:0] CHAIN_PAT  = 32'hFFFF_0000,
  parameter logic [N_IN-1:0] INV_MASK_A = '0,
  parameter logic [N_IN-1:0] INV_MASK_B = '0,
  parameter int              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_clear,
  input  logic              key_load_valid,
  output logic              key_load_ready,
  input  logic [LOAD_W-1:0] key_load_data,
  output logic              key_armed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  input  logic              orig_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [CNT_W-1:0]  query_cnt
);

  localparam int N_BEATS = n_beats(KEY_W, LOAD_W);
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  if (!cfg_ok(N_IN, KEY_W, LOAD_W)) begin : g_bad_cfg
    $error("cas_lock_seq: need N_IN >= 2, KEY_W == 2*N_IN and KEY_W a multiple of LOAD_W");
  end

  lock_state_e        state_q, state_d;
  logic [BEAT_W-1:0]  beat_cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic               beat_acc;
  logic               q_acc;
  logic               last_beat;
  logic               acc_a, acc_b;
  logic               casop_p0;
  logic               vld_p1;
  logic               bit_p1;
  logic [CNT_W-1:0]   cnt_q;

  assign last_beat = (beat_cnt_q == BEAT_W'(N_BEATS - 1));
  assign beat_acc  = key_load_valid & key_load_ready;
  assign q_acc     = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; key_clear overrides everything.
  always_comb begin
    state_d        = state_q;
    key_load_ready = 1'b0;
    key_armed      = 1'b0;
    in_ready       = 1'b0;
    case (state_q)
      EMPTY, LOADING: begin
        key_load_ready = ~key_clear;
        if (key_load_valid && !key_clear) state_d = last_beat ? ARMED : LOADING;
      end
      ARMED: begin
        key_armed = 1'b1;
        in_ready  = ~key_clear & (~vld_p1 | out_ready);
      end
      default: state_d = EMPTY;
    endcase
    if (key_clear) state_d = EMPTY;
  end

  // Beat counter and key register: beat k lands at key[k*LOAD_W +: LOAD_W].
  always_ff @(posedge clk) begin
    if (rst || key_clear) begin
      beat_cnt_q <= '0;
      key_q      <= '0;
    end else if (beat_acc) begin
      beat_cnt_q <= last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
      for (int b = 0; b < N_BEATS; b++) begin
        if (beat_cnt_q == BEAT_W'(b)) key_q[b*LOAD_W +: LOAD_W] <= key_load_data;
      end
    end
  end

  // ---- stage p0: combinational chain evaluation of the offered query ----
  cas_chain #(
    .N_IN     (N_IN),
    .PAT      (CHAIN_PAT),
    .INV_MASK (INV_MASK_A)
  ) u_chain_a (
    .in_data (in_data),
    .key     (key_q[N_IN-1:0]),
    .acc     (acc_a)
  );

  cas_chain #(
    .N_IN     (N_IN),
    .PAT      (CHAIN_PAT),
    .INV_MASK (INV_MASK_B)
  ) u_chain_b (
    .in_data (in_data),
    .key     (key_q[KEY_W-1:N_IN]),
    .acc     (acc_b)
  );

  assign casop_p0 = acc_a & ~acc_b;

  // ---- stage p1: registered result, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst || key_clear) begin
      vld_p1 <= 1'b0;
      bit_p1 <= 1'b0;
    end else if (q_acc) begin
      vld_p1 <= 1'b1;
      bit_p1 <= orig_bit ^ casop_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Saturating count of accepted queries; survives key_clear.
  always_ff @(posedge clk) begin
    if (rst)                                  cnt_q <= '0;
    else if (q_acc && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign out_valid = vld_p1;
  assign out_bit   = bit_p1;
  assign query_cnt = cnt_q;

endmodule
